// File: rtl/regfile_mp.sv
// ---------------------------------------------------------------------------
// regfile_mp -- parametrised multi-port register file for the ARM/RISC-V core.
//
// Purpose:
//   NRD combinational read ports and NWR synchronous write ports over an
//   NREGS x XLEN array. The array has no reset of its own. Instead, a
//   sequential clear engine zeroes one entry per cycle after reset or on
//   clr_req, and busy is high while it runs. Mode-dependent read overrides:
//   x0 reads zero in RISC-V mode, and r15 reads the supplied PC value in
//   ARM mode. Optional same-cycle write-to-read bypass.
//
// Ports:
//   clk      in   clock, all state updates on posedge
//   reset    in   synchronous reset, active-high
//   armD     in   1 = ARM mode, 0 = RISC-V mode
//   clr_req  in   start a clear sweep (honoured only when not busy)
//   we       in   [NWR]        per-port write enable
//   wa       in   [NWR*AW]     write addresses, port i at [i*AW +: AW]
//   wd       in   [NWR*XLEN]   write data, port i at [i*XLEN +: XLEN]
//   ra       in   [NRD*AW]     read addresses, port j at [j*AW +: AW]
//   r15      in   [XLEN]       ARM PC+8 value returned for r15 reads
//   rd       out  [NRD*XLEN]   read data, port j at [j*XLEN +: XLEN]
//   busy     out  high while the clear sweep runs
// ---------------------------------------------------------------------------

// One read port: resolves the mode overrides, the range check, the bypass
// and the array lookup in priority order.
module regfile_mp_rdport #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NWR    = 2,
    parameter int BYPASS = 1,
    parameter int AW     = $clog2(NREGS)
) (
    input  logic [AW-1:0]                  ra,
    input  logic                           armD,
    input  logic                           ready,
    input  logic [XLEN-1:0]                r15,
    input  logic [NREGS-1:0][XLEN-1:0]     rf,
    input  logic [NWR-1:0]                 wen,
    input  logic [NWR-1:0][AW-1:0]         wa_v,
    input  logic [NWR-1:0][XLEN-1:0]       wd_v,
    output logic [XLEN-1:0]                rd
);
    localparam logic [AW:0] NREGS_W = (AW+1)'(NREGS);

    logic            byp_hit;
    logic [XLEN-1:0] byp_data;

    // wen already excludes dropped writes, so a dropped write never forwards.
    // Scanning upward lets the highest-index port win.
    always_comb begin
        byp_hit  = 1'b0;
        byp_data = '0;
        for (int i = 0; i < NWR; i++) begin
            if (wen[i] && (wa_v[i] == ra)) begin
                byp_hit  = 1'b1;
                byp_data = wd_v[i];
            end
        end
    end

    always_comb begin
        rd = '0;
        if (!ready)
            rd = '0;
        else if (armD && (ra[3:0] == 4'hF))
            rd = r15;
        else if (!armD && (ra == '0))
            rd = '0;
        else if ({1'b0, ra} >= NREGS_W)
            rd = '0;
        else if ((BYPASS != 0) && byp_hit)
            rd = byp_data;
        else
            rd = rf[ra];
    end
endmodule

module regfile_mp #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NRD    = 3,
    parameter int NWR    = 2,
    parameter int BYPASS = 1,
    parameter int AW     = $clog2(NREGS)   // derived; leave at default
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 armD,
    input  logic                 clr_req,
    input  logic [NWR-1:0]       we,
    input  logic [NWR*AW-1:0]    wa,
    input  logic [NWR*XLEN-1:0]  wd,
    input  logic [NRD*AW-1:0]    ra,
    input  logic [XLEN-1:0]      r15,
    output logic [NRD*XLEN-1:0]  rd,
    output logic                 busy
);
    localparam logic [AW:0]   NREGS_W = (AW+1)'(NREGS);
    localparam logic [AW-1:0] LAST    = AW'(NREGS-1);

    typedef enum logic {S_CLEAR = 1'b0, S_READY = 1'b1} state_t;

    state_t                      state_q, state_d;
    logic [AW-1:0]               cnt_q, cnt_d;
    logic                        busy_q, busy_d;
    logic [NREGS-1:0][XLEN-1:0]  rf_q, rf_d;

    logic [NWR-1:0][AW-1:0]      wa_v;
    logic [NWR-1:0][XLEN-1:0]    wd_v;
    logic [NWR-1:0]              wen;
    logic                        ready;

    assign ready = (state_q == S_READY);

    // Per-port write qualification. A write is dropped when it is out of
    // range, targets x0 in RISC-V mode, or targets r15 (low nibble F) in ARM
    // mode. A reset cycle also suppresses writes because the sweep follows.
    for (genvar i = 0; i < NWR; i++) begin : g_wr
        assign wa_v[i] = wa[i*AW +: AW];
        assign wd_v[i] = wd[i*XLEN +: XLEN];
        assign wen[i]  = we[i] && ready && !reset
                         && ({1'b0, wa_v[i]} < NREGS_W)
                         && !(!armD && (wa_v[i] == '0))
                         && !(armD && (wa_v[i][3:0] == 4'hF));
    end

    // Sweep control. Reset has priority and is handled in the flop block.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_CLEAR: begin
                cnt_d = cnt_q + AW'(1);
                if (cnt_q == LAST)
                    state_d = S_READY;
            end
            S_READY: begin
                if (clr_req) begin
                    state_d = S_CLEAR;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_CLEAR;
                cnt_d   = '0;
            end
        endcase
        busy_d = (state_d == S_CLEAR);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    // Storage update. The sweep owns the array while clearing. In READY,
    // later ports overwrite earlier ones on an address collision. Writes in a
    // clr_req cycle still land, and the sweep zeroes them afterwards.
    always_comb begin
        rf_d = rf_q;
        if (state_q == S_CLEAR) begin
            rf_d[cnt_q] = '0;
        end else begin
            for (int i = 0; i < NWR; i++) begin
                if (wen[i])
                    rf_d[wa_v[i]] = wd_v[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        rf_q <= rf_d;
    end

    for (genvar j = 0; j < NRD; j++) begin : g_rd
        regfile_mp_rdport #(
            .XLEN   (XLEN),
            .NREGS  (NREGS),
            .NWR    (NWR),
            .BYPASS (BYPASS),
            .AW     (AW)
        ) u_rdport (
            .ra    (ra[j*AW +: AW]),
            .armD  (armD),
            .ready (ready),
            .r15   (r15),
            .rf    (rf_q),
            .wen   (wen),
            .wa_v  (wa_v),
            .wd_v  (wd_v),
            .rd    (rd[j*XLEN +: XLEN])
        );
    end

    assign busy = busy_q;
endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;
    logic        clk, reset, armD, clr_req;
    logic [1:0]  we;
    logic [9:0]  wa;
    logic [63:0] wd;
    logic [14:0] ra;
    logic [31:0] r15;
    logic [95:0] rd, rd_nb;
    logic        busy, busy_nb;

    int n_vec = 0;
    int n_err = 0;

    regfile_mp #(.BYPASS(1)) dut (
        .clk(clk), .reset(reset), .armD(armD), .clr_req(clr_req),
        .we(we), .wa(wa), .wd(wd), .ra(ra), .r15(r15),
        .rd(rd), .busy(busy)
    );

    regfile_mp #(.BYPASS(0)) dut_nb (
        .clk(clk), .reset(reset), .armD(armD), .clr_req(clr_req),
        .we(we), .wa(wa), .wd(wd), .ra(ra), .r15(r15),
        .rd(rd_nb), .busy(busy_nb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout reached");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic        arm;
        logic [1:0]  we;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic [4:0]  ra0, ra1, ra2;
        logic [31:0] r15;
        logic [31:0] e0, e1, e2;   // expected rd on the bypassing instance
        logic [31:0] enb;          // expected rd0 on the non-bypassing instance
    } vec_t;

    vec_t tbl [20];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Counts busy cycles from the current cycle. Every busy cycle must read
    // zero on all ports. Returns at a negedge, either when busy drops (write
    // enables are released before the next edge) or after lim cycles.
    task automatic run_sweep(input int lim, output int n);
        n = 0;
        for (int k = 0; k < lim; k++) begin
            @(negedge clk);
            if (!busy) begin
                we = 2'b00;
                return;
            end
            n++;
            chk("sweep_rd0", rd[31:0], 32'h0);
            chk("sweep_rd1", rd[63:32], 32'h0);
            chk("sweep_rd2", rd[95:64], 32'h0);
            chk("sweep_nb_rd0", rd_nb[31:0], 32'h0);
            if (n < lim) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        int n;
        // arm we  wa0    wd0            wa1    wd1            ra0    ra1    ra2    r15            e0             e1             e2             enb
        tbl[0]  = '{1'b0, 2'b01, 5'd5,  32'hDEADBEEF, 5'd0,  32'h0,        5'd5,  5'd5,  5'd5,  32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0};
        tbl[1]  = '{1'b0, 2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        5'd5,  5'd5,  5'd5,  32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
        tbl[2]  = '{1'b0, 2'b01, 5'd0,  32'h1234,     5'd0,  32'h0,        5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        32'h0,        32'h0};
        tbl[3]  = '{1'b0, 2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        5'd0,  5'd5,  5'd0,  32'h0,        32'h0,        32'hDEADBEEF, 32'h0,        32'h0};
        tbl[4]  = '{1'b0, 2'b10, 5'd0,  32'h0,        5'd7,  32'hA5A5A5A5, 5'd7,  5'd7,  5'd5,  32'h0,        32'hA5A5A5A5, 32'hA5A5A5A5, 32'hDEADBEEF, 32'h0};
        tbl[5]  = '{1'b0, 2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        5'd7,  5'd7,  5'd7,  32'h0,        32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5};
        tbl[6]  = '{1'b0, 2'b11, 5'd9,  32'h11,       5'd9,  32'h22,       5'd9,  5'd9,  5'd9,  32'h0,        32'h22,       32'h22,       32'h22,       32'h0};
        tbl[7]  = '{1'b0, 2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        5'd9,  5'd9,  5'd9,  32'h0,        32'h22,       32'h22,       32'h22,       32'h22};
        tbl[8]  = '{1'b0, 2'b11, 5'd10, 32'h33,       5'd11, 32'h44,       5'd10, 5'd11, 5'd9,  32'h0,        32'h33,       32'h44,       32'h22,       32'h0};
        tbl[9]  = '{1'b1, 2'b01, 5'd0,  32'hC0FFEE,   5'd0,  32'h0,        5'd0,  5'd15, 5'd5,  32'h1008,     32'hC0FFEE,   32'h1008,     32'hDEADBEEF, 32'h0};
        tbl[10] = '{1'b1, 2'b01, 5'd15, 32'h55,       5'd0,  32'h0,        5'd0,  5'd15, 5'd15, 32'h1008,     32'hC0FFEE,   32'h1008,     32'h1008,     32'hC0FFEE};
        tbl[11] = '{1'b0, 2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        5'd15, 5'd0,  5'd10, 32'h1008,     32'h0,        32'h0,        32'h33,       32'h0};
        tbl[12] = '{1'b1, 2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        5'd0,  5'd31, 5'd31, 32'hABCD0000, 32'hC0FFEE,   32'hABCD0000, 32'hABCD0000, 32'hC0FFEE};
        tbl[13] = '{1'b1, 2'b10, 5'd0,  32'h0,        5'd31, 32'h99,       5'd31, 5'd31, 5'd11, 32'h1008,     32'h1008,     32'h1008,     32'h44,       32'h1008};
        tbl[14] = '{1'b0, 2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        5'd31, 5'd11, 5'd10, 32'h1008,     32'h0,        32'h44,       32'h33,       32'h0};
        tbl[15] = '{1'b0, 2'b01, 5'd15, 32'hF15,      5'd0,  32'h0,        5'd15, 5'd5,  5'd9,  32'h0,        32'hF15,      32'hDEADBEEF, 32'h22,       32'h0};
        tbl[16] = '{1'b1, 2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        5'd15, 5'd15, 5'd15, 32'h8,        32'h8,        32'h8,        32'h8,        32'h8};
        tbl[17] = '{1'b0, 2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        5'd15, 5'd0,  5'd0,  32'h8,        32'hF15,      32'h0,        32'h0,        32'hF15};
        tbl[18] = '{1'b0, 2'b01, 5'd3,  32'h77,       5'd0,  32'h0,        5'd3,  5'd3,  5'd3,  32'h0,        32'h77,       32'h77,       32'h77,       32'h0};
        tbl[19] = '{1'b0, 2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        5'd3,  5'd3,  5'd3,  32'h0,        32'h77,       32'h77,       32'h77,       32'h77};

        reset = 1'b1; armD = 1'b0; clr_req = 1'b0; we = '0; wa = '0; wd = '0;
        ra = '0; r15 = '0;

        // Reset held for three edges, with busy high after each one.
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            chk("reset_busy", 32'(busy), 32'h1);
            chk("reset_busy_nb", 32'(busy_nb), 32'h1);
        end
        reset = 1'b0;

        // First sweep. The r15 override must also be masked while busy.
        armD = 1'b1; r15 = 32'h1008; ra = {5'd6, 5'd5, 5'd15};
        run_sweep(100, n);
        chk("sweep_len", 32'(n), 32'd32);
        @(posedge clk);
        #1;

        // Every address reads zero once the sweep is done.
        armD = 1'b0; r15 = '0;
        for (int a = 0; a < 32; a++) begin
            ra = {5'd0, 5'd0, 5'(a)};
            #1;
            chk($sformatf("post_clear_x%0d", a), rd[31:0], 32'h0);
        end

        // Directed vectors, one per cycle.
        for (int i = 0; i < 20; i++) begin
            armD = tbl[i].arm;
            we   = tbl[i].we;
            wa   = {tbl[i].wa1, tbl[i].wa0};
            wd   = {tbl[i].wd1, tbl[i].wd0};
            ra   = {tbl[i].ra2, tbl[i].ra1, tbl[i].ra0};
            r15  = tbl[i].r15;
            @(negedge clk);
            chk($sformatf("v%0d_rd0", i), rd[31:0], tbl[i].e0);
            chk($sformatf("v%0d_rd1", i), rd[63:32], tbl[i].e1);
            chk($sformatf("v%0d_rd2", i), rd[95:64], tbl[i].e2);
            chk($sformatf("v%0d_nb_rd0", i), rd_nb[31:0], tbl[i].enb);
            @(posedge clk);
            #1;
        end
        we = '0; armD = 1'b0; r15 = '0;

        // Mid-sweep reset, with a write to x3 held throughout.
        we = 2'b01; wa = {5'd0, 5'd3}; wd = {32'h0, 32'h77}; ra = {5'd3, 5'd3, 5'd3};
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        run_sweep(10, n);
        chk("midsweep_first10", 32'(n), 32'd10);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        run_sweep(100, n);
        chk("midsweep_restart_len", 32'(n), 32'd32);
        @(posedge clk);
        #1;
        chk("busy_write_ignored", rd[31:0], 32'h0);
        chk("busy_write_ignored_nb", rd_nb[31:0], 32'h0);

        // Write in READY, then a clr_req sweep wipes it.
        we = 2'b01; wa = {5'd0, 5'd3}; wd = {32'h0, 32'h77};
        @(posedge clk);
        #1;
        we = 2'b00;
        chk("x3_written", rd[31:0], 32'h77);
        chk("x3_written_nb", rd_nb[31:0], 32'h77);
        clr_req = 1'b1;
        @(posedge clk);
        #1;
        clr_req = 1'b0;
        chk("clr_req_busy", 32'(busy), 32'h1);
        run_sweep(100, n);
        chk("clr_req_sweep_len", 32'(n), 32'd32);
        @(posedge clk);
        #1;
        chk("x3_cleared", rd[31:0], 32'h0);
        chk("x3_cleared_nb", rd_nb[31:0], 32'h0);
        chk("ready_after_clr", 32'(busy), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port register file for the combined ARM/RISC-V core, replacing the fixed 2-read/1-write file in the decode stage. It adds configurable read and write port counts, optional same-cycle write-to-read bypass, and a sequential clear engine that zeroes all storage after reset or on request. The mode-dependent read overrides are retained: x0 reads zero in RISC-V mode, and r15 reads the supplied PC value in ARM mode.

Parameters:
XLEN, 32, data width in bits
NREGS, 32, number of architectural registers; power of 2, at least 16
NRD, 3, number of read ports (the third serves ARM register-shifted-register operands)
NWR, 2, number of write ports
BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads see stored value only
AW, $clog2(NREGS), address width (derived, not overridden)

Ports:
clk  input  1  clock; all state updates on posedge clk
reset  input  1  synchronous reset, active-high
armD  input  1  1 = ARM mode, 0 = RISC-V mode (decode-stage mode bit)
clr_req  input  1  request a full clear sweep; sampled only in READY
we  input  NWR  per-port write enable
wa  input  NWR*AW  write addresses; port i at [i*AW +: AW]
wd  input  NWR*XLEN  write data; port i at [i*XLEN +: XLEN]
ra  input  NRD*AW  read addresses; port j at [j*AW +: AW]
r15  input  XLEN  ARM PC+8 value returned for r15 reads
rd  output  NRD*XLEN  read data; port j at [j*XLEN +: XLEN]
busy  output  1  1 while the clear sweep runs

Behaviour:
- FSM states: CLEAR and READY. A counter cnt of width AW drives the sweep.
- Reset (synchronous, any state): next state CLEAR, cnt <= 0.
- Reset mid-sweep restarts the sweep at 0.
- The storage array has no reset of its own and is cleared only by the sweep.
- CLEAR behaviour:
  - Each cycle, rf[cnt] <= 0 and cnt <= cnt+1.
  - When cnt == NREGS-1, that entry is written and the next state is READY.
  - The sweep takes exactly NREGS cycles after reset deasserts.
- busy is 1 in CLEAR and 0 in READY. In the cycle reset is asserted, busy is 1 on the next edge (registered from state).
- While busy:
  - All we are ignored.
  - All rd outputs are 0.
  - clr_req is ignored.
- READY behaviour:
  - clr_req = 1 moves to CLEAR with cnt <= 0.
  - Writes presented in that same cycle are still committed, but the sweep then zeroes them.
- Write rules (READY only):
  - Port i commits wd_i to rf[wa_i] at posedge when we_i = 1.
  - Dropped: wa_i >= NREGS; RISC-V mode with wa_i == 0; ARM mode with wa_i[3:0] == 4'hF.
  - Several ports writing the same address in one cycle: the highest-index enabled port wins.
- Read rules (combinational, READY), priority order:
  1. ARM mode and ra_j[3:0] == 4'hF: r15.
  2. RISC-V mode and ra_j == 0: 0.
  3. ra_j >= NREGS: 0.
  4. BYPASS = 1 and some enabled, non-dropped write port targets ra_j this cycle: that port's wd; the highest index wins.
  5. Otherwise: rf[ra_j].
- Latency: a write is visible the same cycle with BYPASS = 1, and from the next cycle otherwise.
- armD switching: takes effect combinationally on both reads and the write-drop filter; stored contents are unaffected.

Test Plan:
- Reset held 3 cycles, then released -> busy = 1 for exactly 32 cycles; all rd = 0 during the sweep; afterwards, reading every address returns 0.
- RISC-V mode, write 0xDEADBEEF to x5 on port 0; read x5 on ports 0-2 the next cycle -> 0xDEADBEEF. Write 0x1234 to x0, then read x0 -> 0.
- BYPASS = 1: same cycle, port 1 writes x7 = 0xA5A5A5A5 and ra0 = 7 -> rd0 = 0xA5A5A5A5 in that cycle. With BYPASS = 0 -> old value (0) in that cycle, 0xA5A5A5A5 the next cycle.
- Write collision: port 0 writes x9 = 0x11 and port 1 writes x9 = 0x22 in the same cycle -> x9 reads 0x22.
- ARM mode, r15 = 0x00001008: ra0 = 15 -> 0x00001008. Write 0x55 to address 15 -> dropped; ra0 = 0 returns the stored r0 value, not 0.
- Mid-sweep reset: assert reset at sweep cycle 10 -> sweep restarts, busy stays high 32 more cycles. Write x3 = 0x77 while busy -> ignored; x3 reads 0 afterwards. In READY, clr_req pulse -> busy 32 cycles, x3 previously 0x77 then reads 0.
